// File: rtl/mac_engine_l2_if.sv
// Handshake and data bus of the mac_engine_l2 dot-product engine.
// The slave side belongs to the engine; the master side drives start/data.
interface mac_engine_l2_if #(
  parameter int ACC_W = 20
);
  logic                    start;
  logic                    fullFilter;
  logic signed [7:0]       filterByte;
  logic signed [7:0]       inputByte;
  logic                    REFilter;
  logic                    REInput;
  logic                    rstFilter;
  logic signed [ACC_W-1:0] result;
  logic                    resultValid;
  logic                    busy;

  modport slave (
    input  start, fullFilter, filterByte, inputByte,
    output REFilter, REInput, rstFilter, result, resultValid, busy
  );

  modport master (
    output start, fullFilter, filterByte, inputByte,
    input  REFilter, REInput, rstFilter, result, resultValid, busy
  );
endinterface

// File: rtl/mac_engine_l2.sv
// mac_engine_l2: sequential signed 8x8 dot product over KERNEL_LEN byte pairs.
// Sequence per accepted start: IDLE -> ARM -> FETCH (KERNEL_LEN) -> DRAIN -> DONE.
// Buffers answer a read-enable one cycle later, so accumulation follows
// REFilter delayed by one cycle (pair-valid flag).
// Optional feature: define MAC_ENGINE_RELU_EN to clamp negative results to 0.
module mac_engine_l2 #(
  parameter int KERNEL_LEN = 16,
  parameter int ACC_W      = 20
) (
  input  logic           clk,
  input  logic           rst,
  mac_engine_l2_if.slave bus
);
  localparam int CNT_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;

  typedef enum logic [2:0] {IDLE, ARM, FETCH, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pv_q, pv_d;
  logic                    re_q, re_d;
  logic                    rsf_q, rsf_d;
  logic                    busy_q, busy_d;
  logic                    vld_q, vld_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] res_q, res_d;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] acc_sum;

  // Value loaded into the result register from the final accumulator.
  function automatic logic signed [ACC_W-1:0] out_value(input logic signed [ACC_W-1:0] a);
`ifdef MAC_ENGINE_RELU_EN
    return a[ACC_W-1] ? '0 : a;
`else
    return a;
`endif
  endfunction

  // Product of the aligned byte pair and the wrapping running sum.
  always_comb begin
    prod    = bus.filterByte * bus.inputByte;
    acc_sum = acc_q + $signed({{(ACC_W-16){prod[15]}}, prod});
  end

  // Next state, counter, accumulator and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pv_d    = re_q;
    acc_d   = pv_q ? acc_sum : acc_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (bus.start && bus.fullFilter) state_d = ARM;
      end
      ARM: begin
        acc_d   = '0;
        cnt_d   = CNT_W'(KERNEL_LEN - 1);
        state_d = FETCH;
      end
      FETCH: begin
        if (cnt_q == '0) state_d = DRAIN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DRAIN: begin
        res_d   = out_value(acc_d);
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    re_d   = (state_d == FETCH);
    rsf_d  = (state_d == ARM);
    busy_d = (state_d != IDLE);
    vld_d  = (state_d == DONE);
  end

  // State and output registers; reset returns everything to an idle, cleared engine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pv_q    <= 1'b0;
      re_q    <= 1'b0;
      rsf_q   <= 1'b0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      re_q    <= re_d;
      rsf_q   <= rsf_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  // While reset is held the buffers rewind and no reads are issued.
  assign bus.rstFilter   = rsf_q | rst;
  assign bus.REFilter    = re_q & ~rst;
  assign bus.REInput     = re_q & ~rst;
  assign bus.busy        = busy_q & ~rst;
  assign bus.result      = res_q;
  assign bus.resultValid = vld_q;
endmodule

// File: tb/tb_mac_engine_l2.sv
// Bench for mac_engine_l2: directed table, randomized ops against a sum model,
// and multi-cycle sequences (no fullFilter, reset mid-fetch, held start).
module tb_mac_engine_l2;
  localparam int K  = 16;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_engine_l2_if #(.ACC_W(AW)) bus ();

  mac_engine_l2 #(.KERNEL_LEN(K), .ACC_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Filter/feature buffers: synchronous read, pointer rewound by rstFilter.
  logic signed [7:0] fmem [K];
  logic signed [7:0] xmem [K];
  logic signed [7:0] fb_r = '0;
  logic signed [7:0] xb_r = '0;
  int ptr = 0;
  assign bus.filterByte = fb_r;
  assign bus.inputByte  = xb_r;

  always @(posedge clk) begin
    if (bus.rstFilter) ptr <= 0;
    else if (bus.REFilter) begin
      fb_r <= fmem[ptr % K];
      xb_r <= xmem[ptr % K];
      ptr  <= ptr + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Dot product of the buffers, wrapped to AW bits, optional clamp.
  function automatic logic signed [AW-1:0] model();
    longint s = 0;
    logic signed [AW-1:0] r;
    for (int i = 0; i < K; i++) s += longint'(fmem[i]) * longint'(xmem[i]);
    r = s[AW-1:0];
`ifdef MAC_ENGINE_RELU_EN
    if (r < 0) r = '0;
`endif
    return r;
  endfunction

  task automatic fill(input logic [7:0] f, input logic [7:0] x);
    for (int i = 0; i < K; i++) begin
      fmem[i] = f;
      xmem[i] = x;
    end
  endtask

  // One operation; latency counts edges from the start-sampling edge to the
  // edge that first samples resultValid high.
  task automatic run_op(input string nm, input logic signed [AW-1:0] exp, input bit drop_full);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.fullFilter = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (drop_full) bus.fullFilter = 1'b0;
    n = 1;
    while (!bus.resultValid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, K + 3);
    chk({nm, "_res"}, bus.result, exp);
    @(negedge clk);
    chk({nm, "_vld_once"}, bus.resultValid, 0);
    repeat (3) @(negedge clk);
    chk({nm, "_hold"}, bus.result, exp);
    bus.fullFilter = 1'b1;
  endtask

  typedef struct {
    logic [7:0] f;
    logic [7:0] x;
    bit         drop_full;
    int         exp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int bad;
    int t;
    int p [$];

`ifdef MAC_ENGINE_RELU_EN
    tbl[0] = '{8'h01, 8'h02, 1'b0, 32};
    tbl[1] = '{8'hFF, 8'h7F, 1'b0, 0};
    tbl[2] = '{8'h80, 8'h80, 1'b0, 262144};
    tbl[3] = '{8'h7F, 8'h7F, 1'b1, 258064};
    tbl[4] = '{8'h80, 8'h7F, 1'b0, 0};
`else
    tbl[0] = '{8'h01, 8'h02, 1'b0, 32};
    tbl[1] = '{8'hFF, 8'h7F, 1'b0, -2032};
    tbl[2] = '{8'h80, 8'h80, 1'b0, 262144};
    tbl[3] = '{8'h7F, 8'h7F, 1'b1, 258064};
    tbl[4] = '{8'h80, 8'h7F, 1'b0, -260096};
`endif

    rst = 1'b1;
    bus.start = 1'b0;
    bus.fullFilter = 1'b0;
    fill(8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_rstFilter", bus.rstFilter, 1);
    chk("rst_REFilter", bus.REFilter, 0);
    chk("rst_REInput", bus.REInput, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_valid", bus.resultValid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rstFilter", bus.rstFilter, 0);

    for (int i = 0; i < 5; i++) begin
      fill(tbl[i].f, tbl[i].x);
      run_op($sformatf("vec%0d", i), AW'(tbl[i].exp), tbl[i].drop_full);
    end

    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < K; i++) begin
        fmem[i] = 8'($urandom);
        xmem[i] = 8'($urandom);
      end
      run_op($sformatf("rand%0d", r), model(), r[0]);
    end

    // Start without a full filter buffer must be ignored.
    bus.fullFilter = 1'b0;
    bus.start = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.REFilter || bus.busy || bus.resultValid) bad++;
    end
    chk("nofull_ignored", bad, 0);
    bus.start = 1'b0;
    bus.fullFilter = 1'b1;

    // Reset in the 5th FETCH cycle, then a clean restart.
    fill(8'h01, 8'h02);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midfetch_re_before", bus.REFilter, 1);
    rst = 1'b1;
    #1;
    chk("midfetch_rstFilter", bus.rstFilter, 1);
    chk("midfetch_busy_in_rst", bus.busy, 0);
    @(negedge clk);
    chk("midfetch_re_after", bus.REFilter, 0);
    chk("midfetch_vld_after", bus.resultValid, 0);
    chk("midfetch_result_clr", bus.result, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("postrst_idle", bus.busy, 0);
    run_op("restart", 32, 1'b0);

    // Held start: pulses 20 cycles apart, DONE does not re-accept.
    fill(8'h01, 8'h02);
    @(negedge clk);
    bus.start = 1'b1;
    t = 0;
    while (p.size() < 3 && t < 200) begin
      @(negedge clk);
      t++;
      if (bus.resultValid) begin
        p.push_back(t);
        chk($sformatf("held_res%0d", p.size()), bus.result, 32);
      end
    end
    chk("held_pulses", p.size(), 3);
    if (p.size() == 3) begin
      chk("held_gap1", p[1] - p[0], K + 4);
      chk("held_gap2", p[2] - p[1], K + 4);
    end
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    chk("held_end_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_engine_l2.md
MAC_ENGINE_L2 -- requirements
Module: mac_engine_l2

Interface
REQ-001 Parameter KERNEL_LEN, default 16: number of byte pairs per dot product; legal range 2..16.
REQ-002 Parameter ACC_W, default 20: accumulator and result width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port start, input, 1: request one dot product.
REQ-006 Port fullFilter, input, 1: the filter buffer holds a complete kernel.
REQ-007 Port filterByte, input, 8: signed filter byte from the filter buffer.
REQ-008 Port inputByte, input, 8: signed feature byte, aligned with filterByte.
REQ-009 Port REFilter, output, 1: read-enable to the filter buffer.
REQ-010 Port REInput, output, 1: read-enable to the feature buffer; identical to REFilter.
REQ-011 Port rstFilter, output, 1: rewinds the filter buffer read pointer.
REQ-012 Port result, output, ACC_W: signed dot product.
REQ-013 Port resultValid, output, 1: result is valid for exactly one cycle.
REQ-014 Port busy, output, 1: high in every state except IDLE.

Function
REQ-015 The FSM shall have the states IDLE, ARM, FETCH, DRAIN and DONE.
REQ-016 In IDLE, start=1 with fullFilter=1 shall move the FSM to ARM; start with fullFilter=0 shall be ignored.
REQ-017 ARM shall last exactly 1 cycle, drive rstFilter=1, clear the accumulator, then enter FETCH.
REQ-018 FETCH shall last exactly KERNEL_LEN cycles with REFilter=REInput=1 and a down-counter from KERNEL_LEN-1 to 0, then enter DRAIN.
REQ-019 A pair-valid flag shall be REFilter delayed by one cycle; in each cycle where it is 1, filterByte*inputByte (signed 8x8, 16-bit product, sign-extended to ACC_W) shall be added to the accumulator at the closing edge.
REQ-020 DRAIN shall last 1 cycle and perform the final accumulation, then enter DONE.
REQ-021 DONE shall last 1 cycle with resultValid=1 and result driven from a register loaded at the DRAIN-to-DONE edge, then return to IDLE.
REQ-022 resultValid shall first be high KERNEL_LEN+3 rising edges after the edge that samples an accepted start.
REQ-023 result shall hold its value until the next DONE.
REQ-024 Accumulation shall wrap modulo 2^ACC_W with no saturation.
REQ-025 start shall be ignored in every state other than IDLE, including DONE, so the next accept is possible no earlier than the cycle after DONE.
REQ-026 rstFilter, REFilter and REInput shall be 0 in every state not listed above.
REQ-027 fullFilter shall be sampled only in IDLE; its deassertion after accept shall have no effect.

Reset
REQ-028 rst=1 at a rising edge shall force IDLE and clear the accumulator, counter, pair-valid flag, result register (result=0) and resultValid; this applies in any state, including mid-FETCH.
REQ-029 While rst=1, rstFilter shall be 1 and REFilter, REInput and busy shall be 0.
REQ-030 After reset, no operation shall start until a new accepted start.

Configuration
REQ-031 With macro MAC_ENGINE_RELU_EN defined, the value loaded into the result register shall be 0 when the accumulator is negative, and the accumulator value otherwise.
REQ-032 Without MAC_ENGINE_RELU_EN, result shall be the raw signed accumulator value.

Verification
REQ-033 With KERNEL_LEN=16, all filter bytes 0x01, all input bytes 0x02 and start pulsed with fullFilter=1, the bench shall observe result=32 and resultValid high 19 edges after start.
REQ-034 With filter bytes 0xFF, input bytes 0x7F and start, the bench shall observe result=-2032, or 0 with MAC_ENGINE_RELU_EN defined.
REQ-035 With filter bytes 0x80 and input bytes 0x80, the bench shall observe result=0x40000 and no wrap.
REQ-036 With start and fullFilter=0, the bench shall observe REFilter=0, busy=0 and no resultValid for 30 cycles.
REQ-037 With rst asserted in the 5th FETCH cycle, the bench shall observe REFilter=0 and resultValid=0 the next cycle; a restart then gives the correct result of 32.
REQ-038 With start held high continuously, the bench shall observe consecutive resultValid pulses spaced 20 cycles apart and start ignored in DONE.
